// File: rtl/circ_vec_sequencer.sv
// Exhaustive 16-vector sweep driver and checker for the 4-in/3-out test circuit.
// Each vector settles for SETTLE cycles, then the outputs are captured and graded.
module circ_vec_sequencer #(
    parameter int unsigned SETTLE = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic [2:0] dut_out,
    output logic [3:0] vec,
    output logic       busy,
    output logic       cap_valid,
    output logic [3:0] cap_vec,
    output logic [2:0] cap_out,
    output logic       mismatch,
    output logic [4:0] err_count,
    output logic       done,
    output logic       pass
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_SETTLE  = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    localparam logic [7:0] CNT_LAST = 8'(SETTLE - 1);

    logic [1:0] state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] vec_q, vec_d;
    logic       busy_q, busy_d;
    logic       cap_valid_q, cap_valid_d;
    logic [3:0] cap_vec_q, cap_vec_d;
    logic [2:0] cap_out_q, cap_out_d;
    logic       mismatch_q, mismatch_d;
    logic [4:0] err_q, err_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;

    logic       a, b, c, d;
    logic       g1, w5, g2;
    logic [2:0] golden;
    logic       miss;

    always_comb begin
        {a, b, c, d} = vec_q;
        g1     = ~((~a & b) & (c | d));
        w5     = a & ~c & ~d;
        g2     = g1 ^ w5;
        golden = {g1, g2, g2};
        miss   = (dut_out != golden);
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        vec_d       = vec_q;
        busy_d      = busy_q;
        cap_valid_d = 1'b0;
        cap_vec_d   = cap_vec_q;
        cap_out_d   = cap_out_q;
        mismatch_d  = mismatch_q;
        err_d       = err_q;
        done_d      = 1'b0;
        pass_d      = pass_q;
        unique case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    vec_d   = 4'd0;
                    cnt_d   = 8'd0;
                    err_d   = 5'd0;
                    pass_d  = 1'b0;
                    busy_d  = 1'b1;
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (abort) begin
                    vec_d   = 4'd0;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_CAPTURE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_CAPTURE: begin
                if (abort) begin
                    vec_d   = 4'd0;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    cap_valid_d = 1'b1;
                    cap_vec_d   = vec_q;
                    cap_out_d   = dut_out;
                    mismatch_d  = miss;
                    if (miss) begin
                        err_d = err_q + 5'd1;
                    end
                    if (vec_q == 4'd15) begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        vec_d   = vec_q + 4'd1;
                        cnt_d   = 8'd0;
                        state_d = S_SETTLE;
                    end
                end
            end
            S_DONE: begin
                // err_q already includes the last vector's result here
                pass_d  = (err_q == 5'd0);
                busy_d  = 1'b0;
                vec_d   = 4'd0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 8'd0;
            vec_q       <= 4'd0;
            busy_q      <= 1'b0;
            cap_valid_q <= 1'b0;
            cap_vec_q   <= 4'd0;
            cap_out_q   <= 3'd0;
            mismatch_q  <= 1'b0;
            err_q       <= 5'd0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            vec_q       <= vec_d;
            busy_q      <= busy_d;
            cap_valid_q <= cap_valid_d;
            cap_vec_q   <= cap_vec_d;
            cap_out_q   <= cap_out_d;
            mismatch_q  <= mismatch_d;
            err_q       <= err_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
        end
    end

    assign vec       = vec_q;
    assign busy      = busy_q;
    assign cap_valid = cap_valid_q;
    assign cap_vec   = cap_vec_q;
    assign cap_out   = cap_out_q;
    assign mismatch  = mismatch_q;
    assign err_count = err_q;
    assign done      = done_q;
    assign pass      = pass_q;

endmodule

// File: tb/tb_circ_vec_sequencer.sv
// Bench for circ_vec_sequencer: delayed behavioural circuit with injectable
// per-vector output faults, graded against a sweep-level reference model.
module tb_circ_vec_sequencer;

    localparam int SET   = 20;
    localparam int P     = SET + 1;
    localparam int LASTC = 16 * P + 1;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic [2:0] dut_out;
    logic [3:0] vec;
    logic       busy;
    logic       cap_valid;
    logic [3:0] cap_vec;
    logic [2:0] cap_out;
    logic       mismatch;
    logic [4:0] err_count;
    logic       done;
    logic       pass;

    int n_checks = 0;
    int n_fail   = 0;

    logic [2:0] fmask [16];
    logic [3:0] hist  [18];

    circ_vec_sequencer #(.SETTLE(SET)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .dut_out   (dut_out),
        .vec       (vec),
        .busy      (busy),
        .cap_valid (cap_valid),
        .cap_vec   (cap_vec),
        .cap_out   (cap_out),
        .mismatch  (mismatch),
        .err_count (err_count),
        .done      (done),
        .pass      (pass)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] gold(input int v);
        int a, b, c, d;
        logic g1, w5, g2;
        a  = (v >> 3) & 1;
        b  = (v >> 2) & 1;
        c  = (v >> 1) & 1;
        d  = v & 1;
        g1 = !((a == 0) && (b == 1) && (c == 1 || d == 1));
        w5 = (a == 1) && (c == 0) && (d == 0);
        g2 = g1 ^ w5;
        return {g1, g2, g2};
    endfunction

    // Circuit model: outputs follow the inputs 18 cycles late
    always @(posedge clk) begin
        hist[0] <= vec;
        for (int i = 1; i < 18; i++) hist[i] <= hist[i-1];
    end
    assign dut_out = gold(int'(hist[17])) ^ fmask[hist[17]];

    task automatic run_sweep(input int abort_at, input int rst_at,
                             input int p0, input int p1, input int p2,
                             output int err_out);
        int  err;
        int  endc;
        int  idx;
        bit  ab;
        bit  exp_cv;
        bit  exp_done;
        bit  exp_busy;
        logic [3:0] exp_vec;
        logic [2:0] exp_out;
        err  = 0;
        endc = (abort_at > 0) ? abort_at + 20 : LASTC + 1;
        @(negedge clk);
        start = 1'b1;
        for (int c = 1; c <= endc; c++) begin
            @(negedge clk);
            ab       = (abort_at > 0) && (c > abort_at);
            exp_busy = !ab && (c <= LASTC);
            if (ab || c > LASTC) exp_vec = 4'd0;
            else if (c == LASTC) exp_vec = 4'd15;
            else exp_vec = 4'((c - 1) / P);
            exp_cv   = !ab && c >= P + 1 && ((c - 1) % P == 0) && c <= LASTC;
            exp_done = !ab && c == LASTC;
            n_checks++;
            if (vec !== exp_vec) begin
                n_fail++;
                $display("FAIL vec cyc=%0d got=%0d exp=%0d", c, vec, exp_vec);
            end
            n_checks++;
            if (busy !== exp_busy) begin
                n_fail++;
                $display("FAIL busy cyc=%0d got=%b exp=%b", c, busy, exp_busy);
            end
            n_checks++;
            if (cap_valid !== exp_cv) begin
                n_fail++;
                $display("FAIL cap_valid cyc=%0d got=%b exp=%b",
                         c, cap_valid, exp_cv);
            end
            if (exp_cv) begin
                idx     = (c - 1) / P - 1;
                exp_out = gold(idx) ^ fmask[idx];
                if (fmask[idx] != 3'd0) err++;
                n_checks++;
                if (cap_vec !== 4'(idx) || cap_out !== exp_out ||
                    mismatch !== (fmask[idx] != 3'd0)) begin
                    n_fail++;
                    $display("FAIL capture cyc=%0d got=%0d/%0h/%b exp=%0d/%0h/%b",
                             c, cap_vec, cap_out, mismatch, idx, exp_out,
                             fmask[idx] != 3'd0);
                end
            end
            n_checks++;
            if (done !== exp_done) begin
                n_fail++;
                $display("FAIL done cyc=%0d got=%b exp=%b", c, done, exp_done);
            end
            if (exp_done) begin
                n_checks++;
                if (err_count !== 5'(err)) begin
                    n_fail++;
                    $display("FAIL err_at_done got=%0d exp=%0d", err_count, err);
                end
            end
            if (c == rst_at) begin
                rst_n = 1'b0;
                #1;
                n_checks++;
                if ({vec, busy, cap_valid, cap_vec, cap_out, mismatch,
                     err_count, done, pass} !== 21'd0) begin
                    n_fail++;
                    $display("FAIL midsweep_reset got=%0h exp=0",
                             {vec, busy, cap_valid, cap_vec, cap_out,
                              mismatch, err_count, done, pass});
                end
                start = 1'b0;
                abort = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                err_out = err;
                return;
            end
            start = (c == p0 || c == p1 || c == p2);
            abort = (c == abort_at);
        end
        start = 1'b0;
        abort = 1'b0;
        n_checks++;
        if (err_count !== 5'(err)) begin
            n_fail++;
            $display("FAIL err_final got=%0d exp=%0d", err_count, err);
        end
        n_checks++;
        if (pass !== (abort_at == 0 && err == 0)) begin
            n_fail++;
            $display("FAIL pass got=%b exp=%b", pass, abort_at == 0 && err == 0);
        end
        err_out = err;
    endtask

    task automatic clear_faults();
        for (int v = 0; v < 16; v++) fmask[v] = 3'd0;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({vec, busy, cap_valid, cap_vec, cap_out, mismatch,
             err_count, done, pass} !== 21'd0) begin
            n_fail++;
            $display("FAIL reset_async got=%0h exp=0",
                     {vec, busy, cap_valid, cap_vec, cap_out,
                      mismatch, err_count, done, pass});
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            n_checks++;
            if (vec !== 4'd0 || busy !== 1'b0 ||
                cap_valid !== 1'b0 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_idle got=%0h/%b/%b/%b exp=0/0/0/0",
                         vec, busy, cap_valid, done);
            end
        end
    endtask

    task automatic test_clean_sweep();
        int e;
        clear_faults();
        run_sweep(0, 0, -1, -1, -1, e);
        n_checks++;
        if (pass !== 1'b1) begin
            n_fail++;
            $display("FAIL clean_pass got=%b exp=1", pass);
        end
    endtask

    task automatic test_stuck_out1();
        int e;
        for (int v = 0; v < 16; v++) fmask[v] = {gold(v) & 3'b100};
        run_sweep(0, 0, -1, -1, -1, e);
        n_checks++;
        if (err_count !== 5'd13 || pass !== 1'b0) begin
            n_fail++;
            $display("FAIL stuck_out1 got=%0d/%b exp=13/0", err_count, pass);
        end
        clear_faults();
    endtask

    task automatic test_start_while_busy();
        int e;
        clear_faults();
        run_sweep(0, 0, 5, 100, 336, e);
    endtask

    task automatic test_abort();
        int e;
        fmask[0] = 3'b001;
        run_sweep(50, 0, -1, -1, -1, e);
        n_checks++;
        if (err_count !== 5'd1) begin
            n_fail++;
            $display("FAIL abort_err_hold got=%0d exp=1", err_count);
        end
        clear_faults();
        test_clean_sweep();
    endtask

    task automatic test_reset_midsweep();
        int e;
        clear_faults();
        run_sweep(0, 9 * P + 10, -1, -1, -1, e);
        test_clean_sweep();
    endtask

    task automatic test_random();
        int e;
        for (int s = 0; s < 5; s++) begin
            for (int v = 0; v < 16; v++)
                fmask[v] = ($urandom_range(3) == 0) ?
                           3'($urandom_range(7, 1)) : 3'd0;
            repeat ($urandom_range(5)) @(negedge clk);
            if (s == 4)
                run_sweep($urandom_range(16 * P, 1), 0, -1, -1, -1, e);
            else
                run_sweep(0, 0, $urandom_range(LASTC, 1), -1, -1, e);
        end
        clear_faults();
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        clear_faults();
        for (int i = 0; i < 18; i++) hist[i] = 4'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_clean_sweep();
        test_stuck_out1();
        test_start_while_busy();
        test_abort();
        test_reset_midsweep();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
